// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver.
// Takes the raw PS/2 clock and data lines and rebuilds 11-bit frames from them:
// start bit, 8 data bits LSB first, odd parity, stop bit.
// Both lines are synchronized, and the clock is also debounced.
// A frame is then decoded on the falling edges of the debounced clock.
// Good frames update the scan code and produce a one-cycle strobe.
// Parity errors, bad stop bits and stalled frames produce a one-cycle error pulse instead.
module ps2_kbd_rx #(
    parameter int FREQ_HZ        = 25000000,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2500
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] ps2_kbd_code_o,
    output logic       ps2_kbd_strobe_o,
    output logic       ps2_kbd_err_o
);

    // FREQ_HZ only records the clock rate that TIMEOUT_CYCLES was sized for.
    // It is multiplied by zero so that it is referenced but has no effect.
    localparam int FREQ_UNUSED = FREQ_HZ * 0;

    // The filter counter counts the mismatching samples seen so far.
    // The filtered clock flips on the last sample of a run of FILTER_LEN mismatches.
    localparam logic [3:0]  FILTER_LAST   = 4'(FILTER_LEN - 1);
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES + FREQ_UNUSED);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic        clk_meta;
    logic        clk_sync;
    logic        data_meta;
    logic        data_sync;
    logic [3:0]  filter_cnt;
    logic        clk_filt;
    logic        clk_filt_prev;
    logic        fall;
    logic        timeout_hit;
    logic        parity_good;

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        parity_bit;
    logic [15:0] tmo_cnt;

    // Two-flop synchronizers on both PS/2 lines.
    // They reset to the idle-high level so that leaving reset does not look like an edge.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_i;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data_i;
            data_sync <= data_meta;
        end
    end

    // Debounce the synchronized clock.
    // The filtered level changes only after FILTER_LEN consecutive samples that differ from it.
    // Any shorter excursion resets the run count and is ignored.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            filter_cnt <= 4'd0;
            clk_filt   <= 1'b1;
        end else if (clk_sync == clk_filt) begin
            filter_cnt <= 4'd0;
        end else if (filter_cnt == FILTER_LAST) begin
            filter_cnt <= 4'd0;
            clk_filt   <= clk_sync;
        end else begin
            filter_cnt <= filter_cnt + 4'd1;
        end
    end

    // Keep the previous filtered level so that a falling edge can be detected.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            clk_filt_prev <= 1'b1;
        end else begin
            clk_filt_prev <= clk_filt;
        end
    end

    assign fall        = clk_filt_prev & ~clk_filt;
    assign timeout_hit = (tmo_cnt == TIMEOUT_LIMIT);

    // Odd parity: the eight data bits plus the parity bit must hold an odd number of ones.
    assign parity_good = ^{shift_reg, parity_bit};

    // Frame decoder with registered outputs.
    // The stall counter runs whenever a frame is open and is cleared by every clock edge.
    // An edge takes priority over a timeout that expires in the same cycle,
    // because that edge proves the keyboard is still sending.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state            <= IDLE;
            bit_cnt          <= 3'd0;
            shift_reg        <= 8'h00;
            parity_bit       <= 1'b0;
            tmo_cnt          <= 16'd0;
            ps2_kbd_code_o   <= 8'h00;
            ps2_kbd_strobe_o <= 1'b0;
            ps2_kbd_err_o    <= 1'b0;
        end else begin
            ps2_kbd_strobe_o <= 1'b0;
            ps2_kbd_err_o    <= 1'b0;

            if (state == IDLE || fall) begin
                tmo_cnt <= 16'd0;
            end else begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (fall && !data_sync) begin
                        state   <= DATA;
                        bit_cnt <= 3'd0;
                    end
                end

                DATA: begin
                    if (fall) begin
                        shift_reg <= {data_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end else if (timeout_hit) begin
                        state         <= IDLE;
                        shift_reg     <= 8'h00;
                        ps2_kbd_err_o <= 1'b1;
                    end
                end

                PARITY: begin
                    if (fall) begin
                        parity_bit <= data_sync;
                        state      <= STOP;
                    end else if (timeout_hit) begin
                        state         <= IDLE;
                        shift_reg     <= 8'h00;
                        ps2_kbd_err_o <= 1'b1;
                    end
                end

                STOP: begin
                    if (fall) begin
                        state <= IDLE;
                        if (data_sync && parity_good) begin
                            ps2_kbd_code_o   <= shift_reg;
                            ps2_kbd_strobe_o <= 1'b1;
                        end else begin
                            ps2_kbd_err_o <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state         <= IDLE;
                        shift_reg     <= 8'h00;
                        ps2_kbd_err_o <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Testbench for ps2_kbd_rx.
// It plays PS/2 frames with a 200-cycle clock period, including glitches and stalled frames.
// Strobe and error pulses are counted by a monitor,
// and the counts, codes and pulse timing are compared against hand-computed values.
module tb_ps2_kbd_rx;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 2500;
    localparam int LATENCY        = 3 + FILTER_LEN;
    localparam int HALF           = 100;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_data_i = 1'b1;
    logic [7:0] ps2_kbd_code_o;
    logic       ps2_kbd_strobe_o;
    logic       ps2_kbd_err_o;

    int total = 0;
    int bad = 0;
    int cycle_count = 0;
    int strobe_high = 0;
    int err_high = 0;
    int both_high = 0;
    int last_event_cycle = -1;
    int last_fall_cycle = 0;

    typedef struct {
        logic [7:0] code;
        logic       par;
        logic       stop;
        int         exp_strobe;
        int         exp_err;
        logic [7:0] exp_code;
    } vec_t;

    vec_t vecs[4];

    ps2_kbd_rx #(
        .FREQ_HZ(25000000),
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .reset_i(reset_i),
        .ps2_clk_i(ps2_clk_i),
        .ps2_data_i(ps2_data_i),
        .ps2_kbd_code_o(ps2_kbd_code_o),
        .ps2_kbd_strobe_o(ps2_kbd_strobe_o),
        .ps2_kbd_err_o(ps2_kbd_err_o)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter, used to time output pulses against pin edges.
    always @(posedge clk) cycle_count <= cycle_count + 1;

    // Count the cycles during which the outputs are high.
    // Sampling happens on the falling clock edge, away from the active edge.
    always @(negedge clk) begin
        if (ps2_kbd_strobe_o) begin
            strobe_high = strobe_high + 1;
            last_event_cycle = cycle_count;
        end
        if (ps2_kbd_err_o) begin
            err_high = err_high + 1;
            last_event_cycle = cycle_count;
        end
        if (ps2_kbd_strobe_o && ps2_kbd_err_o) begin
            both_high = both_high + 1;
        end
    end

    // Hard stop in case the run stalls.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against the value it should have.
    task automatic checkOutput(input string name, input int actual, input int expected);
        total = total + 1;
        if (actual != expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Drive the first n_bits bits of a frame, starting with the start bit.
    // If glitch_at matches a bit index, the clock is pulled low for glitch_len cycles
    // during that bit's trailing high phase.
    task automatic applyStimulus(input logic [7:0] code, input logic par, input logic stop,
                                 input int n_bits, input int glitch_at, input int glitch_len);
        logic [10:0] frame;
        frame = {stop, par, code, 1'b0};
        for (int i = 0; i < n_bits; i++) begin
            @(negedge clk);
            ps2_data_i = frame[i];
            repeat (HALF / 2) @(negedge clk);
            ps2_clk_i = 1'b0;
            last_fall_cycle = cycle_count;
            repeat (HALF) @(negedge clk);
            ps2_clk_i = 1'b1;
            if (i == glitch_at) begin
                repeat (20) @(negedge clk);
                ps2_clk_i = 1'b0;
                repeat (glitch_len) @(negedge clk);
                ps2_clk_i = 1'b1;
                repeat (30 - glitch_len) @(negedge clk);
            end else begin
                repeat (HALF / 2) @(negedge clk);
            end
        end
    endtask

    // Send a complete frame and check its outcome.
    // The outcome pulse lands a few cycles after the stop-bit falling edge,
    // which is well before the task returns.
    task automatic runFrame(input string tag, input logic [7:0] code, input logic par,
                            input logic stop, input int exp_strobe, input int exp_err,
                            input logic [7:0] exp_code, input int glitch_at);
        int s0;
        int e0;
        s0 = strobe_high;
        e0 = err_high;
        applyStimulus(code, par, stop, 11, glitch_at, 2);
        checkOutput({tag, "_strobe"}, strobe_high - s0, exp_strobe);
        checkOutput({tag, "_err"}, err_high - e0, exp_err);
        checkOutput({tag, "_code"}, int'(ps2_kbd_code_o), int'(exp_code));
        checkOutput({tag, "_latency"}, last_event_cycle - last_fall_cycle, LATENCY);
    endtask

    initial begin
        int s0;
        int e0;
        int waited;
        int err_cycle;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
        vecs[1] = '{8'hF0, 1'b1, 1'b1, 1, 0, 8'hF0};
        vecs[2] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
        vecs[3] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h1C};

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_code", int'(ps2_kbd_code_o), 0);
        checkOutput("reset_strobe", int'(ps2_kbd_strobe_o), 0);
        checkOutput("reset_err", int'(ps2_kbd_err_o), 0);
        reset_i = 1'b0;
        repeat (10) @(negedge clk);

        // Table of frames sent back to back: a good frame, a break pair, then a bad parity.
        for (int i = 0; i < 4; i++) begin
            runFrame($sformatf("vec%0d", i), vecs[i].code, vecs[i].par, vecs[i].stop,
                     vecs[i].exp_strobe, vecs[i].exp_err, vecs[i].exp_code, -1);
        end

        // Bad stop bit: 0x5A with parity 1 but stop 0. The code must keep 0x1C.
        runFrame("badstop", 8'h5A, 1'b1, 1'b0, 0, 1, 8'h1C, -1);

        // Stalled frame: start plus five data bits, then the clock stays high.
        s0 = strobe_high;
        e0 = err_high;
        applyStimulus(8'h33, 1'b0, 1'b1, 6, -1, 0);
        waited = 0;
        while (err_high == e0 && waited < TIMEOUT_CYCLES + 500) begin
            @(negedge clk);
            waited = waited + 1;
        end
        err_cycle = last_event_cycle;
        repeat (5) @(negedge clk);
        checkOutput("timeout_err", err_high - e0, 1);
        checkOutput("timeout_strobe", strobe_high - s0, 0);
        checkOutput("timeout_latency", err_cycle - last_fall_cycle,
                    LATENCY + TIMEOUT_CYCLES + 1);
        checkOutput("timeout_code", int'(ps2_kbd_code_o), 8'h1C);
        runFrame("after_timeout", 8'h5A, 1'b1, 1'b1, 1, 0, 8'h5A, -1);

        // Short clock glitches while idle, with the data line low.
        // A glitch that got through would look like a start bit.
        s0 = strobe_high;
        e0 = err_high;
        @(negedge clk);
        ps2_data_i = 1'b0;
        repeat (10) @(negedge clk);
        ps2_clk_i = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk_i = 1'b1;
        repeat (10) @(negedge clk);
        ps2_clk_i = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        ps2_clk_i = 1'b1;
        repeat (10) @(negedge clk);
        ps2_data_i = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("idle_glitch_strobe", strobe_high - s0, 0);
        checkOutput("idle_glitch_err", err_high - e0, 0);

        // Glitch in the middle of a frame: the glitch comes after data bit 2 (frame index 3).
        runFrame("glitch_frame", 8'h29, 1'b0, 1'b1, 1, 0, 8'h29, 3);

        // Reset pulse after the fourth data bit of 0x1C.
        s0 = strobe_high;
        e0 = err_high;
        applyStimulus(8'h1C, 1'b0, 1'b1, 5, -1, 0);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        checkOutput("midreset_code", int'(ps2_kbd_code_o), 0);
        repeat (TIMEOUT_CYCLES + 100) @(negedge clk);
        checkOutput("midreset_strobe", strobe_high - s0, 0);
        checkOutput("midreset_err", err_high - e0, 0);
        runFrame("after_reset", 8'h76, 1'b0, 1'b1, 1, 0, 8'h76, -1);

        // Strobe and err must never be high in the same cycle.
        checkOutput("never_both", both_high, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
